// File: rtl/uart_receiver_fifo.sv
// UART receive path with a first-word-fall-through FIFO.
// LSB-first frames, optional parity, one or two stop bits, 3-point majority
// sampling per bit. Each completed frame is queued together with its parity
// and framing error flags; the FIFO is drained through a valid/ready handshake.
module uart_receiver_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          serial_data_in,
  input  logic [5:0]                    prescale,
  input  logic                          parity_enable,
  input  logic                          parity_type,
  input  logic                          two_stop_bits,
  input  logic                          rx_ready,
  input  logic                          overrun_clear,
  output logic                          rx_valid,
  output logic [DATA_WIDTH-1:0]         rx_data,
  output logic                          rx_parity_error,
  output logic                          rx_frame_error,
  output logic                          overrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int EW = DATA_WIDTH + 2;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [2:0]            r_state;
  logic [5:0]            r_ecnt;
  logic [5:0]            r_p;
  logic                  r_par_en;
  logic                  r_par_type;
  logic                  r_two_stop;
  logic [BW-1:0]         r_bitidx;
  logic                  r_stopidx;
  logic [DATA_WIDTH-1:0] r_data;
  logic [2:0]            r_smp;
  logic                  r_perr;
  logic                  r_ferr;

  logic [EW-1:0]         r_mem [FIFO_DEPTH];
  logic [AW-1:0]         r_wptr;
  logic [AW-1:0]         r_rptr;
  logic [CW-1:0]         r_count;
  logic                  r_overrun;

  logic [5:0]            w_half;
  logic                  w_last_e;
  logic                  w_bit;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_full;
  logic                  w_wr;
  logic [EW-1:0]         w_entry;
  logic [EW-1:0]         w_head;

  assign w_half   = {1'b0, r_p[5:1]};
  assign w_last_e = (r_ecnt == (r_p - 6'd1));
  assign w_bit    = (r_smp[0] & r_smp[1]) | (r_smp[0] & r_smp[2]) | (r_smp[1] & r_smp[2]);

  // The last stop bit's own verdict is folded in directly so the entry is
  // written on the same edge the bit is decided.
  assign w_push  = (r_state == S_STOP) && w_last_e && (r_stopidx == r_two_stop);
  assign w_entry = {r_perr, r_ferr | ~w_bit, r_data};

  assign w_full = (r_count == CW'(FIFO_DEPTH));
  assign w_pop  = (r_count != '0) && rx_ready;
  assign w_wr   = w_push && (!w_full || w_pop);

  // Receive FSM: bit timing, majority sampling, frame assembly.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_ecnt     <= '0;
      r_p        <= '0;
      r_par_en   <= 1'b0;
      r_par_type <= 1'b0;
      r_two_stop <= 1'b0;
      r_bitidx   <= '0;
      r_stopidx  <= 1'b0;
      r_data     <= '0;
      r_smp      <= '0;
      r_perr     <= 1'b0;
      r_ferr     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!serial_data_in) begin
            // The detecting cycle counts as e=0 of the start bit.
            r_state    <= S_START;
            r_ecnt     <= 6'd1;
            r_p        <= prescale;
            r_par_en   <= parity_enable;
            r_par_type <= parity_type;
            r_two_stop <= two_stop_bits;
          end
        end
        S_START, S_DATA, S_PARITY, S_STOP: begin
          if (w_last_e) r_ecnt <= '0;
          else          r_ecnt <= r_ecnt + 6'd1;
          if (r_ecnt == (w_half - 6'd1)) r_smp[0] <= serial_data_in;
          if (r_ecnt == w_half)          r_smp[1] <= serial_data_in;
          if (r_ecnt == (w_half + 6'd1)) r_smp[2] <= serial_data_in;
          if (w_last_e) begin
            case (r_state)
              S_START: begin
                if (!w_bit) begin
                  r_state  <= S_DATA;
                  r_bitidx <= '0;
                  r_perr   <= 1'b0;
                  r_ferr   <= 1'b0;
                end else begin
                  r_state <= S_IDLE;
                end
              end
              S_DATA: begin
                r_data[r_bitidx] <= w_bit;
                if (r_bitidx == BW'(DATA_WIDTH - 1)) begin
                  r_state   <= r_par_en ? S_PARITY : S_STOP;
                  r_stopidx <= 1'b0;
                end else begin
                  r_bitidx <= r_bitidx + BW'(1);
                end
              end
              S_PARITY: begin
                r_perr  <= w_bit ^ (^r_data) ^ r_par_type;
                r_state <= S_STOP;
              end
              default: begin
                if (!w_bit) r_ferr <= 1'b1;
                if (r_stopidx == r_two_stop) r_state   <= S_IDLE;
                else                         r_stopidx <= 1'b1;
              end
            endcase
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // FIFO storage; contents are only observed through the valid-gated outputs.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr] <= w_entry;
  end

  // FIFO pointers, occupancy and sticky overrun.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
      r_overrun <= 1'b0;
    end else begin
      if (w_wr)  r_wptr <= r_wptr + AW'(1);
      if (w_pop) r_rptr <= r_rptr + AW'(1);
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_push && !w_wr)  r_overrun <= 1'b1;
      else if (overrun_clear) r_overrun <= 1'b0;
    end
  end

  assign w_head          = r_mem[r_rptr];
  assign rx_valid        = (r_count != '0);
  assign rx_data         = rx_valid ? w_head[DATA_WIDTH-1:0] : '0;
  assign rx_frame_error  = rx_valid & w_head[DATA_WIDTH];
  assign rx_parity_error = rx_valid & w_head[DATA_WIDTH+1];
  assign overrun         = r_overrun;
  assign fifo_count      = r_count;

endmodule

// File: tb/tb_uart_receiver_fifo.sv
// Directed bench for uart_receiver_fifo: all stimulus and sampling on the
// falling clock edge, one serial bit held for exactly P clock cycles.
module tb_uart_receiver_fifo;

  logic       clk = 1'b0;
  logic       reset;
  logic       serial_data_in;
  logic [5:0] prescale;
  logic       parity_enable;
  logic       parity_type;
  logic       two_stop_bits;
  logic       rx_ready;
  logic       overrun_clear;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_parity_error;
  logic       rx_frame_error;
  logic       overrun;
  logic [2:0] fifo_count;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  uart_receiver_fifo #(.DATA_WIDTH(8), .FIFO_DEPTH(4)) dut (
    .clk             (clk),
    .reset           (reset),
    .serial_data_in  (serial_data_in),
    .prescale        (prescale),
    .parity_enable   (parity_enable),
    .parity_type     (parity_type),
    .two_stop_bits   (two_stop_bits),
    .rx_ready        (rx_ready),
    .overrun_clear   (overrun_clear),
    .rx_valid        (rx_valid),
    .rx_data         (rx_data),
    .rx_parity_error (rx_parity_error),
    .rx_frame_error  (rx_frame_error),
    .overrun         (overrun),
    .fifo_count      (fifo_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Hold one bit for p cycles; optionally invert it for the single cycle
  // sampled at e=p/2.
  task automatic send_bit(input logic b, input int p, input bit glitch);
    serial_data_in = b;
    if (!glitch) begin
      repeat (p) @(negedge clk);
    end else begin
      repeat (p / 2) @(negedge clk);
      serial_data_in = ~b;
      @(negedge clk);
      serial_data_in = b;
      repeat (p - p / 2 - 1) @(negedge clk);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input int p, input bit pen, input logic pbit,
                            input int nstop, input logic stopval, input int gbit);
    send_bit(1'b0, p, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i], p, (i == gbit));
    if (pen) send_bit(pbit, p, 1'b0);
    for (int s = 0; s < nstop; s++) send_bit(stopval, p, 1'b0);
    serial_data_in = 1'b1;
  endtask

  task automatic pop_one();
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  initial begin
    logic [7:0] exp_q [4];
    reset          = 1'b0;
    serial_data_in = 1'b1;
    prescale       = 6'd16;
    parity_enable  = 1'b0;
    parity_type    = 1'b0;
    two_stop_bits  = 1'b0;
    rx_ready       = 1'b0;
    overrun_clear  = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_valid", rx_valid, 1'b0);
    check("rst_data", rx_data, 8'h00);
    check("rst_perr", rx_parity_error, 1'b0);
    check("rst_ferr", rx_frame_error, 1'b0);
    check("rst_overrun", overrun, 1'b0);
    check("rst_count", fifo_count, 3'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // P=16, 8N1, 0xA5
    send_frame(8'hA5, 16, 1'b0, 1'b0, 1, 1'b1, -1);
    check("t1_valid", rx_valid, 1'b1);
    check("t1_data", rx_data, 8'hA5);
    check("t1_perr", rx_parity_error, 1'b0);
    check("t1_ferr", rx_frame_error, 1'b0);
    check("t1_count", fifo_count, 3'd1);
    pop_one();
    check("t1_pop_count", fifo_count, 3'd0);
    check("t1_pop_valid", rx_valid, 1'b0);

    // P=8, even parity, 2 stop bits, 0x3C with wrong parity bit 1
    prescale = 6'd8; parity_enable = 1'b1; parity_type = 1'b0; two_stop_bits = 1'b1;
    @(negedge clk);
    send_frame(8'h3C, 8, 1'b1, 1'b1, 2, 1'b1, -1);
    check("t2_data", rx_data, 8'h3C);
    check("t2_perr", rx_parity_error, 1'b1);
    check("t2_ferr", rx_frame_error, 1'b0);
    pop_one();

    // Same frame under odd parity: parity bit 1 is correct
    parity_type = 1'b1;
    @(negedge clk);
    send_frame(8'h3C, 8, 1'b1, 1'b1, 2, 1'b1, -1);
    check("t2b_data", rx_data, 8'h3C);
    check("t2b_perr", rx_parity_error, 1'b0);
    pop_one();

    // P=32, 8N1, stop bit low -> framing error
    prescale = 6'd32; parity_enable = 1'b0; parity_type = 1'b0; two_stop_bits = 1'b0;
    @(negedge clk);
    send_frame(8'hC3, 32, 1'b0, 1'b0, 1, 1'b0, -1);
    check("t3_data", rx_data, 8'hC3);
    check("t3_ferr", rx_frame_error, 1'b1);
    check("t3_perr", rx_parity_error, 1'b0);
    pop_one();

    // Single-cycle low pulse on idle line is rejected as a false start
    serial_data_in = 1'b0;
    @(negedge clk);
    serial_data_in = 1'b1;
    repeat (40) @(negedge clk);
    check("t3_glitch_count", fifo_count, 3'd0);
    check("t3_glitch_valid", rx_valid, 1'b0);
    send_frame(8'h81, 32, 1'b0, 1'b0, 1, 1'b1, -1);
    check("t3_after_data", rx_data, 8'h81);
    check("t3_after_count", fifo_count, 3'd1);
    pop_one();

    // Mid-bit glitch on data bit 1 is outvoted
    prescale = 6'd16;
    @(negedge clk);
    send_frame(8'h5A, 16, 1'b0, 1'b0, 1, 1'b1, 1);
    check("t4_data", rx_data, 8'h5A);
    check("t4_ferr", rx_frame_error, 1'b0);
    pop_one();

    // Overflow: five back-to-back frames with no consumer
    prescale = 6'd8;
    @(negedge clk);
    exp_q[0] = 8'h11; exp_q[1] = 8'h22; exp_q[2] = 8'h33; exp_q[3] = 8'h44;
    for (int i = 0; i < 4; i++) send_frame(exp_q[i], 8, 1'b0, 1'b0, 1, 1'b1, -1);
    check("t5_full_count", fifo_count, 3'd4);
    check("t5_full_overrun", overrun, 1'b0);
    send_frame(8'h55, 8, 1'b0, 1'b0, 1, 1'b1, -1);
    check("t5_ovr_count", fifo_count, 3'd4);
    check("t5_ovr_flag", overrun, 1'b1);
    check("t5_ovr_head", rx_data, 8'h11);
    overrun_clear = 1'b1;
    @(negedge clk);
    overrun_clear = 1'b0;
    check("t5_ovr_clear", overrun, 1'b0);
    for (int i = 0; i < 4; i++) begin
      check("t5_drain_data", rx_data, exp_q[i]);
      pop_one();
    end
    check("t5_drain_count", fifo_count, 3'd0);

    // Reset in the middle of data bit 4 discards the frame
    prescale = 6'd16;
    @(negedge clk);
    send_bit(1'b0, 16, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 16, 1'b0);
    repeat (8) @(negedge clk);
    reset = 1'b0;
    serial_data_in = 1'b1;
    repeat (3) @(negedge clk);
    check("t6_rst_count", fifo_count, 3'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("t6_idle_valid", rx_valid, 1'b0);
    send_frame(8'h55, 16, 1'b0, 1'b0, 1, 1'b1, -1);
    check("t6_count", fifo_count, 3'd1);
    check("t6_data", rx_data, 8'h55);
    check("t6_ferr", rx_frame_error, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
